mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage data-memory access controller, directly downstream of the execute stage. Captures the execute-stage address, store data, load/store type and destination into the MEM pipeline register, issues one valid/ready request per memory instruction to the data cache, and aligns returned load data. It also builds byte enables, and raises a stall to the hazard unit while an access is outstanding.

## Interface
- ADDR_W, 32, request address width.
- DATA_W, 32, data/bus width; only 32 is supported.
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- MEM_Flush  in  1  clears the MEM register and cancels the access.
- MEM_Wr  in  1  MEM register write enable from the hazard unit.
- EXE_ALUOut  in  32  effective address.
- EXE_OutB  in  32  store data (also old rt value for LWL/LWR merge).
- EXE_LoadType  in  mem_op_t  load kind: NONE, LB, LBU, LH, LHU, LW, LWL, LWR.
- EXE_StoreType  in  mem_op_t  store kind: NONE, SB, SH, SW, SWL, SWR.
- EXE_Dst  in  5  destination register.
- EXE_Exception  in  1  any exception already flagged upstream; suppresses the access.
- req_valid  out  1  cache request valid.
- req_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- req_wstrb  out  4  byte enables; 0 means read.
- req_wdata  out  32  lane-shifted store data.
- req_ready  in  1  cache accepts request.
- resp_valid  in  1  load data valid; one pulse per accepted read.
- resp_rdata  in  32  raw word from cache.
- MEM_Dst  out  5  registered destination.
- MEM_LoadData  out  32  aligned and extended load result.
- MEM_LoadValid  out  1  MEM_LoadData valid for the current MEM instruction.
- MEM_DCacheStall  out  1  freeze all stages up to and including MEM.

## Operation
- Capture happens on `MEM_Wr && !MEM_DCacheStall`.
  - On `MEM_Flush` the register is cleared instead; flush has priority over write.
  - An access is pending when the captured type is not NONE and `EXE_Exception` was 0.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state is IDLE.
- IDLE
  - A capture with an access pending moves to REQ.
- REQ
  - `req_valid=1`.
  - When `req_ready=1`: a store goes to HOLD; a load goes to WAIT.
  - `MEM_Flush` moves to IDLE and drops `req_valid`; no handshake has occurred.
- WAIT
  - When `resp_valid=1`: register the aligned data and go to HOLD.
  - `MEM_Flush` moves to DRAIN.
- HOLD
  - `MEM_LoadValid=1` for loads.
  - A capture moves to REQ (new access pending) or IDLE (no access).
  - `MEM_Flush` moves to IDLE.
- DRAIN
  - Waits for `resp_valid`, discards the data, then moves to IDLE.
- `MEM_DCacheStall = (state==REQ)||(state==WAIT)||(state==DRAIN)`. It is combinational from state only.
- Load alignment:
  - LB/LBU select byte `addr[1:0]`; LH/LHU select half `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes the word through.
- Store lanes:
  - SB: `wstrb = 4'b0001<<addr[1:0]`, data byte replicated ×4.
  - SH: `wstrb = 4'b0011<<{addr[1],1'b0}`, data half replicated ×2.
  - SW: `wstrb = 4'b1111`.
- Misaligned accesses never arrive here without `EXE_Exception=1`.

## Timing
- Reset values: `req_valid=0`, `req_addr=0`, `req_wstrb=0`, `req_wdata=0`, `MEM_Dst=0`, `MEM_LoadData=0`, `MEM_LoadValid=0`, `MEM_DCacheStall=0`.
- `req_valid` rises in the cycle after capture.
- `req_addr`, `req_wstrb` and `req_wdata` are stable while `req_valid=1` and `req_ready=0`.
- Zero-wait cache:
  - A load has REQ(ready) in cycle 1, WAIT(resp) in cycle 2, and HOLD in cycle 3 with `MEM_LoadValid=1`; stall is high for 2 cycles.
  - A store has REQ(ready) in cycle 1 and HOLD in cycle 2; stall is high for 1 cycle.
- `resp_valid` in the same cycle as the accepting `req_ready` is illegal; the cache responds at least one cycle later.
- A flush and a response in the same WAIT cycle: the response is consumed and discarded, and the next state is IDLE, not DRAIN.
- Reset asserted mid-access returns to IDLE immediately. The cache is reset by the same `rst`.

## Configuration
- `MEM_UNALIGNED_LR_EN` defined:
  - LWL/LWR merge selected bytes of `resp_rdata` into `EXE_OutB` per `addr[1:0]`, little-endian MIPS32 rules.
  - SWL/SWR produce partial wstrb/wdata per `addr[1:0]`.
- Undefined: LWL, LWR, SWL and SWR are treated as NONE. No request is issued and `MEM_LoadValid` stays 0. The decoder raises reserved-instruction for them upstream.

## Structure
- The shared CPU definitions package holds:
  - the `mem_op_t` enum;
  - the `mstate_t` FSM enum;
  - `WSTRB_NONE`/`WSTRB_ALL` constants.
- Sub-module `mem_align` is combinational and contains load extract/extend/merge and store lane/strobe generation. The FSM and MEM register stay in `mem_access_ctrl`.

## Test plan
- LB at address 0x103, `resp_rdata=0x80FF_1234` → `req_addr=0x100`, `req_wstrb=0`, `MEM_LoadData=0xFFFF_FF80` on the cycle after resp; stall 2 cycles.
- SH at address 0x202, `EXE_OutB=0x0000_BEEF` → `req_wstrb=4'b1100`, `req_wdata=0xBEEF_BEEF`; HOLD one cycle after `req_ready`.
- `req_ready` held low 3 cycles on an LW → `req_valid`, `req_addr` and `MEM_DCacheStall` held constant for all 3 cycles.
- `MEM_Flush` in WAIT, `resp_valid` 2 cycles later → DRAIN, data discarded, `MEM_LoadValid` stays 0, stall releases the cycle after resp.
- `EXE_Exception=1` with SW → no `req_valid`, stall stays 0.
- With `MEM_UNALIGNED_LR_EN`: LWL at address 0x1, `EXE_OutB=0x1111_1111`, `resp_rdata=0xAABB_CCDD` → `MEM_LoadData=0xCCDD_1111`.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared MEM-stage definitions: memory op kinds, access FSM states, strobe constants.
// Optional feature macro: MEM_UNALIGNED_LR_EN (enables LWL/LWR/SWL/SWR).
package mem_access_ctrl_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_LWL  = 4'd6,
    MEM_LWR  = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SWL  = 4'd11,
    MEM_SWR  = 4'd12
  } mem_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } mstate_t;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_ALL  = 4'b1111;

  // Unaligned left/right ops only count as real accesses when the feature is built in.
  function automatic logic op_is_load(input mem_op_t op);
    case (op)
      MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: return 1'b1;
`ifdef MEM_UNALIGNED_LR_EN
      MEM_LWL, MEM_LWR: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    case (op)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
`ifdef MEM_UNALIGNED_LR_EN
      MEM_SWL, MEM_SWR: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: load byte/half extract, sign/zero extend, LWL/LWR merge,
// and store strobe/data replication. LWL/LWR/SWL/SWR exist only with MEM_UNALIGNED_LR_EN.
module mem_align
  import mem_access_ctrl_pkg::*;
(
  input  mem_op_t     ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  input  logic [31:0] ld_old,
  output logic [31:0] ld_data,
  input  mem_op_t     st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_src,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = 8'(ld_raw >> {ld_off, 3'b000});
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_data = '0;
    case (ld_op)
      MEM_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data = {24'h0, ld_byte};
      MEM_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data = {16'h0, ld_half};
      MEM_LW:  ld_data = ld_raw;
`ifdef MEM_UNALIGNED_LR_EN
      // Little-endian: LWL fills the high bytes of rt, LWR the low bytes.
      MEM_LWL: begin
        case (ld_off)
          2'd0:    ld_data = {ld_raw[7:0],  ld_old[23:0]};
          2'd1:    ld_data = {ld_raw[15:0], ld_old[15:0]};
          2'd2:    ld_data = {ld_raw[23:0], ld_old[7:0]};
          default: ld_data = ld_raw;
        endcase
      end
      MEM_LWR: begin
        case (ld_off)
          2'd0:    ld_data = ld_raw;
          2'd1:    ld_data = {ld_old[31:24], ld_raw[31:8]};
          2'd2:    ld_data = {ld_old[31:16], ld_raw[31:16]};
          default: ld_data = {ld_old[31:8],  ld_raw[31:24]};
        endcase
      end
`endif
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_wstrb = WSTRB_NONE;
    st_wdata = '0;
    case (st_op)
      MEM_SB: begin
        st_wstrb = 4'b0001 << st_off;
        st_wdata = {4{st_src[7:0]}};
      end
      MEM_SH: begin
        st_wstrb = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_src[15:0]}};
      end
      MEM_SW: begin
        st_wstrb = WSTRB_ALL;
        st_wdata = st_src;
      end
`ifdef MEM_UNALIGNED_LR_EN
      MEM_SWL: begin
        st_wstrb = WSTRB_ALL >> (2'd3 - st_off);
        st_wdata = st_src >> {(2'd3 - st_off), 3'b000};
      end
      MEM_SWR: begin
        st_wstrb = WSTRB_ALL << st_off;
        st_wdata = st_src << {st_off, 3'b000};
      end
`endif
      default: begin
        st_wstrb = WSTRB_NONE;
        st_wdata = '0;
      end
    endcase
  end

`ifndef MEM_UNALIGNED_LR_EN
  logic unused_old;
  assign unused_old = ^ld_old;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: MEM pipeline register, cache request FSM,
// load alignment and stall generation. Optional macro: MEM_UNALIGNED_LR_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Flush,
  input  logic              MEM_Wr,
  input  logic [ADDR_W-1:0] EXE_ALUOut,
  input  logic [DATA_W-1:0] EXE_OutB,
  input  mem_op_t           EXE_LoadType,
  input  mem_op_t           EXE_StoreType,
  input  logic [4:0]        EXE_Dst,
  input  logic              EXE_Exception,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  output logic [3:0]        req_wstrb,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic [4:0]        MEM_Dst,
  output logic [DATA_W-1:0] MEM_LoadData,
  output logic              MEM_LoadValid,
  output logic              MEM_DCacheStall
);

  // Handshake: a request transfers on the cycle req_valid && req_ready are both high;
  // address/strobe/data hold steady until then, and the cache answers a read with
  // exactly one resp_valid pulse no earlier than the cycle after the transfer.

  mstate_t           state_q, state_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] outb_q, outb_d;
  mem_op_t           ltype_q, ltype_d;
  logic              is_load_q, is_load_d;
  logic [4:0]        dst_q, dst_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic              lvalid_q, lvalid_d;

  logic              stall;
  logic              capture, cap_load, cap_store;
  logic [31:0]       al_ld_data, al_st_wdata;
  logic [3:0]        al_st_wstrb;

  assign stall = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);

  // Load path sees the MEM register; store path sees execute-stage operands so the
  // lane-shifted request is ready in the register the moment it is captured.
  mem_align u_align (
    .ld_op    (ltype_q),
    .ld_off   (addr_q[1:0]),
    .ld_raw   (resp_rdata),
    .ld_old   (outb_q),
    .ld_data  (al_ld_data),
    .st_op    (EXE_StoreType),
    .st_off   (EXE_ALUOut[1:0]),
    .st_src   (EXE_OutB),
    .st_wstrb (al_st_wstrb),
    .st_wdata (al_st_wdata)
  );

  always_comb begin
    capture   = MEM_Wr && !stall;
    cap_load  = op_is_load(EXE_LoadType) && !EXE_Exception;
    cap_store = op_is_store(EXE_StoreType) && !EXE_Exception;

    state_d   = state_q;
    addr_d    = addr_q;
    outb_d    = outb_q;
    ltype_d   = ltype_q;
    is_load_d = is_load_q;
    dst_d     = dst_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    ldata_d   = ldata_q;

    if (MEM_Flush) begin
      addr_d    = '0;
      outb_d    = '0;
      ltype_d   = MEM_NONE;
      is_load_d = 1'b0;
      dst_d     = '0;
      wstrb_d   = WSTRB_NONE;
      wdata_d   = '0;
      ldata_d   = '0;
    end else if (capture) begin
      addr_d    = EXE_ALUOut;
      outb_d    = EXE_OutB;
      ltype_d   = cap_load ? EXE_LoadType : MEM_NONE;
      is_load_d = cap_load;
      dst_d     = EXE_Dst;
      wstrb_d   = cap_store ? al_st_wstrb : WSTRB_NONE;
      wdata_d   = cap_store ? al_st_wdata : '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!MEM_Flush && capture && (cap_load || cap_store)) state_d = S_REQ;
      end
      S_REQ: begin
        if (MEM_Flush)      state_d = S_IDLE;
        else if (req_ready) state_d = is_load_q ? S_WAIT : S_HOLD;
      end
      S_WAIT: begin
        // A response arriving with the flush is swallowed here, so no drain is needed.
        if (resp_valid) begin
          state_d = MEM_Flush ? S_IDLE : S_HOLD;
          if (!MEM_Flush) ldata_d = al_ld_data;
        end else if (MEM_Flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (MEM_Flush)    state_d = S_IDLE;
        else if (capture) state_d = (cap_load || cap_store) ? S_REQ : S_IDLE;
      end
      S_DRAIN: begin
        if (resp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_valid_d = (state_d == S_REQ);
    lvalid_d    = (state_d == S_HOLD) && is_load_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      outb_q      <= '0;
      ltype_q     <= MEM_NONE;
      is_load_q   <= 1'b0;
      dst_q       <= '0;
      wstrb_q     <= WSTRB_NONE;
      wdata_q     <= '0;
      ldata_q     <= '0;
      lvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      outb_q      <= outb_d;
      ltype_q     <= ltype_d;
      is_load_q   <= is_load_d;
      dst_q       <= dst_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      ldata_q     <= ldata_d;
      lvalid_q    <= lvalid_d;
    end
  end

  assign req_valid       = req_valid_q;
  assign req_addr        = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_wstrb       = wstrb_q;
  assign req_wdata       = wdata_q;
  assign MEM_Dst         = dst_q;
  assign MEM_LoadData    = ldata_q;
  assign MEM_LoadValid   = lvalid_q;
  assign MEM_DCacheStall = stall;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: driver tasks push expected requests, load results
// and stall lengths into queues; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_Flush, MEM_Wr;
  logic [31:0] EXE_ALUOut, EXE_OutB;
  mem_op_t     EXE_LoadType, EXE_StoreType;
  logic [4:0]  EXE_Dst;
  logic        EXE_Exception;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  MEM_Dst;
  logic [31:0] MEM_LoadData;
  logic        MEM_LoadValid, MEM_DCacheStall;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .MEM_Flush(MEM_Flush), .MEM_Wr(MEM_Wr),
    .EXE_ALUOut(EXE_ALUOut), .EXE_OutB(EXE_OutB),
    .EXE_LoadType(EXE_LoadType), .EXE_StoreType(EXE_StoreType),
    .EXE_Dst(EXE_Dst), .EXE_Exception(EXE_Exception),
    .req_valid(req_valid), .req_addr(req_addr), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .MEM_Dst(MEM_Dst), .MEM_LoadData(MEM_LoadData),
    .MEM_LoadValid(MEM_LoadValid), .MEM_DCacheStall(MEM_DCacheStall)
  );

  logic [67:0] exp_req_q[$];    // {addr, wstrb, wdata}
  logic [36:0] exp_load_q[$];   // {dst, data}
  logic [31:0] exp_stall_q[$];  // length of each stall run in cycles
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_lv = 1'b0;
  int          stall_run = 0;
  logic [67:0] r;
  logic [36:0] l;

  always @(negedge clk) begin
    if (req_valid) begin
      if (exp_req_q.size() == 0) begin
        check("req_unexpected", 32'(req_valid), 32'd0);
      end else begin
        r = exp_req_q[0];
        check("req_addr", req_addr, r[67:36]);
        check("req_wstrb", 32'(req_wstrb), 32'(r[35:32]));
        check("req_wdata", req_wdata, r[31:0]);
        if (req_ready) void'(exp_req_q.pop_front());
      end
    end
    if (MEM_LoadValid && !prev_lv) begin
      if (exp_load_q.size() == 0) begin
        check("load_unexpected", 32'(MEM_LoadValid), 32'd0);
      end else begin
        l = exp_load_q.pop_front();
        check("load_data", MEM_LoadData, l[31:0]);
        check("load_dst", 32'(MEM_Dst), 32'(l[36:32]));
      end
    end
    prev_lv = MEM_LoadValid;
    if (MEM_DCacheStall) begin
      stall_run++;
    end else if (stall_run > 0) begin
      if (exp_stall_q.size() == 0) check("stall_unexpected", 32'(stall_run), 32'd0);
      else check("stall_len", 32'(stall_run), exp_stall_q.pop_front());
      stall_run = 0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input mem_op_t ld, input mem_op_t st, input logic [31:0] addr,
                       input logic [31:0] outb, input logic [4:0] dst, input logic exc);
    MEM_Wr = 1'b1; EXE_LoadType = ld; EXE_StoreType = st; EXE_ALUOut = addr;
    EXE_OutB = outb; EXE_Dst = dst; EXE_Exception = exc;
    tick();
    MEM_Wr = 1'b0; EXE_LoadType = MEM_NONE; EXE_StoreType = MEM_NONE; EXE_Exception = 1'b0;
  endtask

  task automatic load_zw(input mem_op_t op, input logic [31:0] addr, input logic [31:0] outb,
                         input logic [31:0] rdata, input logic [4:0] dst,
                         input logic [31:0] exp_addr, input logic [31:0] exp_data);
    exp_req_q.push_back({exp_addr, WSTRB_NONE, 32'h0});
    exp_load_q.push_back({dst, exp_data});
    exp_stall_q.push_back(32'd2);
    req_ready = 1'b1;
    issue(op, MEM_NONE, addr, outb, dst, 1'b0);
    tick();
    resp_valid = 1'b1; resp_rdata = rdata;
    tick();
    resp_valid = 1'b0;
    tick();
  endtask

  task automatic store_zw(input mem_op_t op, input logic [31:0] addr, input logic [31:0] outb,
                          input logic [4:0] dst, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_data);
    exp_req_q.push_back({exp_addr, exp_strb, exp_data});
    exp_stall_q.push_back(32'd1);
    req_ready = 1'b1;
    issue(MEM_NONE, op, addr, outb, dst, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; MEM_Flush = 1'b0; MEM_Wr = 1'b0; EXE_ALUOut = '0; EXE_OutB = '0;
    EXE_LoadType = MEM_NONE; EXE_StoreType = MEM_NONE; EXE_Dst = '0; EXE_Exception = 1'b0;
    req_ready = 1'b1; resp_valid = 1'b0; resp_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_addr", req_addr, 32'd0);
    check("rst_req_wstrb", 32'(req_wstrb), 32'd0);
    check("rst_req_wdata", req_wdata, 32'd0);
    check("rst_mem_dst", 32'(MEM_Dst), 32'd0);
    check("rst_load_data", MEM_LoadData, 32'd0);
    check("rst_load_valid", 32'(MEM_LoadValid), 32'd0);
    check("rst_stall", 32'(MEM_DCacheStall), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // LB sign-extended, SH lanes, then other widths
    load_zw(MEM_LB, 32'h103, 32'h0, 32'h80FF_1234, 5'd3, 32'h100, 32'hFFFF_FF80);
    store_zw(MEM_SH, 32'h202, 32'h0000_BEEF, 5'd7, 32'h200, 4'b1100, 32'hBEEF_BEEF);

    // LW with ready held low three cycles
    exp_req_q.push_back({32'h10C, WSTRB_NONE, 32'h0});
    exp_load_q.push_back({5'd9, 32'h1234_5678});
    exp_stall_q.push_back(32'd5);
    req_ready = 1'b0;
    issue(MEM_LW, MEM_NONE, 32'h10C, 32'h0, 5'd9, 1'b0);
    tick(); tick(); tick();
    req_ready = 1'b1;
    tick();
    resp_valid = 1'b1; resp_rdata = 32'h1234_5678;
    tick();
    resp_valid = 1'b0;
    tick();

    // Flush in WAIT, response two cycles later is drained
    exp_req_q.push_back({32'h20, WSTRB_NONE, 32'h0});
    exp_stall_q.push_back(32'd4);
    issue(MEM_LW, MEM_NONE, 32'h20, 32'h0, 5'd11, 1'b0);
    tick();
    MEM_Flush = 1'b1;
    tick();
    MEM_Flush = 1'b0;
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hDEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    check("drain_dst", 32'(MEM_Dst), 32'd0);
    check("drain_load_valid", 32'(MEM_LoadValid), 32'd0);
    check("drain_load_data", MEM_LoadData, 32'd0);
    tick();

    // SW with upstream exception: no request, no stall
    issue(MEM_NONE, MEM_SW, 32'h300, 32'hCAFE_F00D, 5'd12, 1'b1);
    @(negedge clk);
    check("exc_req_valid", 32'(req_valid), 32'd0);
    check("exc_stall", 32'(MEM_DCacheStall), 32'd0);
    check("exc_dst", 32'(MEM_Dst), 32'd12);
    tick();

    // Flush and response together in WAIT: straight to IDLE
    exp_req_q.push_back({32'h40, WSTRB_NONE, 32'h0});
    exp_stall_q.push_back(32'd2);
    issue(MEM_LW, MEM_NONE, 32'h40, 32'h0, 5'd13, 1'b0);
    tick();
    MEM_Flush = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h5555_AAAA;
    tick();
    MEM_Flush = 1'b0; resp_valid = 1'b0;
    @(negedge clk);
    check("flushresp_stall", 32'(MEM_DCacheStall), 32'd0);
    check("flushresp_load_valid", 32'(MEM_LoadValid), 32'd0);
    tick();

    // Flush in REQ before any handshake
    exp_req_q.push_back({32'h50, WSTRB_NONE, 32'h0});
    exp_stall_q.push_back(32'd1);
    req_ready = 1'b0;
    issue(MEM_LW, MEM_NONE, 32'h50, 32'h0, 5'd14, 1'b0);
    MEM_Flush = 1'b1;
    tick();
    MEM_Flush = 1'b0; req_ready = 1'b1;
    void'(exp_req_q.pop_front());
    @(negedge clk);
    check("reqflush_req_valid", 32'(req_valid), 32'd0);
    tick();

    store_zw(MEM_SB, 32'h401, 32'h0000_00A5, 5'd4, 32'h400, 4'b0010, 32'hA5A5_A5A5);
    load_zw(MEM_LHU, 32'h502, 32'h0, 32'h8001_7FFE, 5'd15, 32'h500, 32'h0000_8001);
    load_zw(MEM_LH, 32'h500, 32'h0, 32'h1234_F00D, 5'd16, 32'h500, 32'hFFFF_F00D);
    load_zw(MEM_LBU, 32'h601, 32'h0, 32'h1122_C433, 5'd17, 32'h600, 32'h0000_00C4);
    store_zw(MEM_SW, 32'h704, 32'h0102_0304, 5'd18, 32'h704, 4'b1111, 32'h0102_0304);

`ifdef MEM_UNALIGNED_LR_EN
    load_zw(MEM_LWL, 32'h1, 32'h1111_1111, 32'hAABB_CCDD, 5'd19, 32'h0, 32'hCCDD_1111);
    store_zw(MEM_SWR, 32'h802, 32'h1122_3344, 5'd20, 32'h800, 4'b1100, 32'h3344_0000);
`else
    issue(MEM_LWL, MEM_NONE, 32'h1, 32'h1111_1111, 5'd19, 1'b0);
    @(negedge clk);
    check("lwl_off_req_valid", 32'(req_valid), 32'd0);
    check("lwl_off_stall", 32'(MEM_DCacheStall), 32'd0);
    tick();
    resp_valid = 1'b1; resp_rdata = 32'hAABB_CCDD;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    check("lwl_off_load_valid", 32'(MEM_LoadValid), 32'd0);
    tick();
`endif

    // Reset during WAIT
    exp_req_q.push_back({32'h900, WSTRB_NONE, 32'h0});
    exp_stall_q.push_back(32'd1);
    issue(MEM_LW, MEM_NONE, 32'h900, 32'h0, 5'd21, 1'b0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", 32'(MEM_DCacheStall), 32'd0);
    check("midrst_req_valid", 32'(req_valid), 32'd0);
    check("midrst_dst", 32'(MEM_Dst), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    check("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    check("load_q_empty", 32'(exp_load_q.size()), 32'd0);
    check("stall_q_empty", 32'(exp_stall_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
